dmem_store_buffer: RTL and testbench

//  Sits between the single-cycle mips core's data port and a slow, handshaked data memory.

---
 rtl/dmem_store_buffer.sv | 215 +++++++++++++++++++++
 tb/tb_dmem_store_buffer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: store FIFO between the core's data port and a slow,
// req/ack handshaked data memory. Stores retire into the FIFO without
// stalling, loads are forwarded from the youngest matching buffered store,
// and load misses stall the core while a memory read is performed.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_memwrite,
  input  logic                    cpu_memread,
  input  logic [AW-1:0]           cpu_addr,
  input  logic [DW-1:0]           cpu_wdata,
  output logic [DW-1:0]           cpu_rdata,
  output logic                    cpu_stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [AW-1:0]           mem_addr,
  output logic [DW-1:0]           mem_wdata,
  input  logic                    mem_ack,
  input  logic [DW-1:0]           mem_rdata,
  output logic                    buf_empty,
  output logic [$clog2(DEPTH):0]  buf_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int WW = AW - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RDV  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;

  logic [WW-1:0]   addr_r [DEPTH];
  logic [DW-1:0]   data_r [DEPTH];
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;
  logic [PW:0]     count_r;
  logic [PW:0]     count_nxt_s;
  logic [DW-1:0]   rdata_r;

  logic [WW-1:0]   cpu_word_s;
  logic            hit_s;
  logic [DW-1:0]   fwd_s;
  logic            miss_s;
  logic            full_s;
  logic            legal_wr_s;
  logic            push_s;
  logic            pop_s;
  logic            unused_addr_s;

  // Byte offset bits play no part in word matching.
  assign unused_addr_s = ^cpu_addr[1:0];
  assign cpu_word_s    = cpu_addr[AW-1:2];

  assign full_s      = (count_r == (PW+1)'(DEPTH));
  assign miss_s      = cpu_memread & ~hit_s;
  // A simultaneous load wins; the store is dropped.
  assign legal_wr_s  = cpu_memwrite & ~cpu_memread;
  assign push_s      = legal_wr_s & ~full_s;
  assign pop_s       = (state_r == WR) & mem_ack;
  assign count_nxt_s = count_r + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};

  assign buf_count = count_r;
  assign buf_empty = (count_r == '0);

  // Search valid entries oldest to youngest so the youngest match wins.
  always_comb begin
    hit_s = 1'b0;
    fwd_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < count_r) && (addr_r[head_r + PW'(i)] == cpu_word_s)) begin
        hit_s = 1'b1;
        fwd_s = data_r[head_r + PW'(i)];
      end else begin
        hit_s = hit_s;
        fwd_s = fwd_s;
      end
    end
  end

  // FIFO storage, circular pointers and occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= '0;
        data_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        addr_r[tail_r] <= cpu_word_s;
        data_r[tail_r] <= cpu_wdata;
        tail_r         <= tail_r + PW'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PW'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Controller state and captured read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      rdata_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == RD) && mem_ack) begin
        rdata_r <= mem_rdata;
      end
    end
  end

  // Next-state decode plus memory-side and core-side outputs.
  always_comb begin
    state_nxt_s = state_r;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    cpu_stall   = 1'b0;
    cpu_rdata   = '0;
    case (state_r)
      IDLE: begin
        if (miss_s) begin
          cpu_stall   = 1'b1;
          state_nxt_s = RD;
        end else if (count_r != '0) begin
          state_nxt_s = WR;
        end else begin
          state_nxt_s = IDLE;
        end
        if (cpu_memread && hit_s) begin
          cpu_rdata = fwd_s;
        end else begin
          cpu_rdata = '0;
        end
      end
      WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr_r[head_r], 2'b00};
        mem_wdata = data_r[head_r];
        if (miss_s) begin
          cpu_stall = 1'b1;
        end else begin
          cpu_stall = 1'b0;
        end
        if (mem_ack) begin
          if (miss_s) begin
            state_nxt_s = RD;
          end else if (count_nxt_s != '0) begin
            state_nxt_s = WR;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = WR;
        end
        if (cpu_memread && hit_s) begin
          cpu_rdata = fwd_s;
        end else begin
          cpu_rdata = '0;
        end
      end
      RD: begin
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = {cpu_word_s, 2'b00};
        cpu_stall = 1'b1;
        if (mem_ack) begin
          state_nxt_s = RDV;
        end else begin
          state_nxt_s = RD;
        end
      end
      RDV: begin
        cpu_rdata = rdata_r;
        if (count_r != '0) begin
          state_nxt_s = WR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    // Full stall looks at the registered count only.
    if (legal_wr_s && full_s) begin
      cpu_stall = 1'b1;
    end else begin
      cpu_stall = cpu_stall;
    end
    if (!reset) begin
      cpu_stall = 1'b0;
      cpu_rdata = '0;
    end else begin
      cpu_stall = cpu_stall;
      cpu_rdata = cpu_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Testbench for dmem_store_buffer: directed scenarios with literal
// expectations plus a randomized core/memory workload, all checked against
// a queue-based behavioural model and an architectural memory image.
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_memwrite;
  logic          cpu_memread;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          buf_empty;
  logic [2:0]    buf_count;

  always #5 clk = ~clk;

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .buf_empty(buf_empty), .buf_count(buf_count)
  );

  // Slow memory contents and the architectural (program-order) view.
  logic [DW-1:0] slow_mem [256];
  logic [DW-1:0] arch     [256];
  assign mem_rdata = slow_mem[mem_addr[9:2]];

  typedef struct packed {
    logic [7:0]    w;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  bit            wr_on;
  int            rd_stage;   // 0 none, 1 read on the bus, 2 delivering
  logic [DW-1:0] rd_cap;
  bit            mem_init = 1'b0;
  bit            chk_en = 1'b0;
  int            passed = 0;
  int            total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit find(input logic [7:0] w, output logic [DW-1:0] d);
    d = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].w == w) begin
        d = q[i].d;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Model update on each clock edge (and on reset assertion).
  bit            u_hit, u_miss, u_ack, u_push;
  int            u_old;
  logic [DW-1:0] u_fwd;
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      if (!mem_init) begin
        for (int i = 0; i < 256; i++) slow_mem[i] = 32'h1000_0000 + i * 32'h0001_0101;
        slow_mem[32]  = 32'hDEAD_BEEF;
        slow_mem[128] = 32'hCAFE_0123;
        mem_init = 1'b1;
      end
      q.delete();
      wr_on = 1'b0;
      rd_stage = 0;
      rd_cap = '0;
      for (int i = 0; i < 256; i++) arch[i] = slow_mem[i];
    end else begin
      u_hit  = find(cpu_addr[9:2], u_fwd);
      u_miss = cpu_memread && !u_hit;
      u_ack  = (wr_on || rd_stage == 1) && mem_ack;
      u_old  = q.size();
      u_push = cpu_memwrite && !cpu_memread && (u_old < DEPTH);
      if (rd_stage == 1) begin
        if (u_ack) begin
          rd_stage = 2;
          rd_cap = slow_mem[cpu_addr[9:2]];
        end
      end else if (rd_stage == 2) begin
        rd_stage = 0;
        wr_on = (u_old > 0);
      end else if (wr_on) begin
        if (u_ack) begin
          slow_mem[q[0].w] = q[0].d;
          void'(q.pop_front());
          if (u_miss) begin
            wr_on = 1'b0;
            rd_stage = 1;
          end else begin
            wr_on = ((q.size() + int'(u_push)) > 0);
          end
        end
      end else begin
        if (u_miss) rd_stage = 1;
        else if (u_old > 0) wr_on = 1'b1;
      end
      if (u_push) begin
        q.push_back('{w: cpu_addr[9:2], d: cpu_wdata});
        arch[cpu_addr[9:2]] = cpu_wdata;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  bit            c_hit, c_req, c_stall;
  logic [DW-1:0] c_fwd, c_rdata;
  logic [AW-1:0] c_addr;
  initial forever begin
    @(negedge clk);
    if (reset && chk_en) begin
      c_hit   = find(cpu_addr[9:2], c_fwd);
      c_req   = wr_on || (rd_stage == 1);
      c_stall = (rd_stage == 1) || (rd_stage == 0 && cpu_memread && !c_hit) ||
                (cpu_memwrite && !cpu_memread && q.size() == DEPTH);
      c_rdata = (rd_stage == 2) ? rd_cap : ((cpu_memread && c_hit) ? c_fwd : '0);
      chk("mem_req", mem_req, c_req);
      chk("cpu_stall", cpu_stall, c_stall);
      chk("cpu_rdata", cpu_rdata, c_rdata);
      chk("buf_count", buf_count, q.size());
      chk("buf_empty", buf_empty, q.size() == 0);
      if (c_req) begin
        c_addr = wr_on ? {22'd0, q[0].w, 2'b00} : {22'd0, cpu_addr[9:2], 2'b00};
        chk("mem_we", mem_we, wr_on);
        chk("mem_addr", mem_addr, c_addr);
        if (wr_on) chk("mem_wdata", mem_wdata, q[0].d);
      end
      if (cpu_memread && !cpu_stall) chk("load_value", cpu_rdata, arch[cpu_addr[9:2]]);
      if (cpu_memwrite && cpu_memread)
        $display("note: illegal store+load at %0t, store ignored", $time);
    end
  end

  task automatic drive(input bit we, input bit re, input logic [31:0] a,
                       input logic [31:0] d, input bit ack);
    cpu_memwrite = we;
    cpu_memread  = re;
    cpu_addr     = a;
    cpu_wdata    = d;
    mem_ack      = ack;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    while ((!buf_empty || mem_req) && g < 50) begin
      tick();
      g++;
    end
    chk("drain_bound", g < 50, 1'b1);
    mem_ack = 1'b0;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  int            ack_pct;
  int            op;
  int            g;
  logic [31:0]   ra;
  logic [31:0]   rd;

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_cpu_stall", cpu_stall, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_buf_count", buf_count, 3'd0);
    chk("rst_buf_empty", buf_empty, 1'b1);
    reset = 1'b1;
    chk_en = 1'b1;
    tick();

    // Reset in the middle of a write with two entries buffered.
    drive(1'b1, 1'b0, 32'h20, 32'h11, 1'b0); tick();
    drive(1'b1, 1'b0, 32'h24, 32'h22, 1'b0); tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); look();
    chk("t1_req_before", mem_req, 1'b1);
    chk("t1_count_before", buf_count, 3'd2);
    reset = 1'b0; look();
    chk("t1_req", mem_req, 1'b0);
    chk("t1_count", buf_count, 3'd0);
    chk("t1_empty", buf_empty, 1'b1);
    chk("t1_stall", cpu_stall, 1'b0);
    tick();
    reset = 1'b1;
    tick();

    // Forwarding from a store still waiting in the buffer.
    drive(1'b1, 1'b0, 32'h54, 32'h7, 1'b0); tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick(); look();
    chk("t2_req", mem_req, 1'b1);
    chk("t2_we", mem_we, 1'b1);
    chk("t2_addr", mem_addr, 32'h54);
    chk("t2_wdata", mem_wdata, 32'h7);
    tick();
    drive(1'b0, 1'b1, 32'h56, 32'h0, 1'b0); look();
    chk("t2_rdata", cpu_rdata, 32'h7);
    chk("t2_stall", cpu_stall, 1'b0);
    tick();
    drain();

    // Youngest of two matching stores wins.
    drive(1'b1, 1'b0, 32'h10, 32'h1, 1'b0); tick();
    drive(1'b1, 1'b0, 32'h10, 32'h2, 1'b0); tick();
    drive(1'b0, 1'b1, 32'h10, 32'h0, 1'b0); look();
    chk("t3_rdata", cpu_rdata, 32'h2);
    chk("t3_stall", cpu_stall, 1'b0);
    tick();
    drain();

    // Full buffer: fifth store stalls until one entry drains.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 32'h40 + 32'(k * 4), 32'h100 + 32'(k), 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 32'h50, 32'h1FF, 1'b0); look();
    chk("t4_stall", cpu_stall, 1'b1);
    chk("t4_count", buf_count, 3'd4);
    tick();
    mem_ack = 1'b1; look();
    chk("t4_stall_ack", cpu_stall, 1'b1);
    tick();
    mem_ack = 1'b0; look();
    chk("t4_stall_drop", cpu_stall, 1'b0);
    chk("t4_count_pop", buf_count, 3'd3);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); look();
    chk("t4_count_push", buf_count, 3'd4);
    drain();

    // Load miss with a three-cycle memory response.
    drive(1'b0, 1'b1, 32'h80, 32'h0, 1'b0); look();
    chk("t5_stall_idle", cpu_stall, 1'b1);
    tick(); look();
    chk("t5_req", mem_req, 1'b1);
    chk("t5_we", mem_we, 1'b0);
    chk("t5_addr", mem_addr, 32'h80);
    chk("t5_stall_rd", cpu_stall, 1'b1);
    tick(); look(); chk("t5_stall_w1", cpu_stall, 1'b1);
    tick(); look(); chk("t5_stall_w2", cpu_stall, 1'b1);
    tick(); mem_ack = 1'b1; look(); chk("t5_stall_ack", cpu_stall, 1'b1);
    tick(); mem_ack = 1'b0; look();
    chk("t5_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("t5_stall_rdv", cpu_stall, 1'b0);
    tick();

    // Load miss with ack tied high: two stall cycles, data in the third.
    drive(1'b0, 1'b1, 32'h84, 32'h0, 1'b1); look();
    chk("lat_c0", cpu_stall, 1'b1);
    tick(); look(); chk("lat_c1", cpu_stall, 1'b1);
    tick(); look();
    chk("lat_c2", cpu_stall, 1'b0);
    chk("lat_rdata", cpu_rdata, 32'h1021_2121);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick();

    // Load miss while a write is in progress.
    drive(1'b1, 1'b0, 32'h30, 32'h77, 1'b0); tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick(); look();
    chk("t6_wr", mem_we, 1'b1);
    drive(1'b0, 1'b1, 32'h200, 32'h0, 1'b0); look();
    chk("t6_stall", cpu_stall, 1'b1);
    tick(); mem_ack = 1'b1; look();
    chk("t6_stall_wack", cpu_stall, 1'b1);
    tick(); mem_ack = 1'b0; look();
    chk("t6_count", buf_count, 3'd0);
    chk("t6_mem_write", slow_mem[12], 32'h77);
    chk("t6_req", mem_req, 1'b1);
    chk("t6_we", mem_we, 1'b0);
    chk("t6_addr", mem_addr, 32'h200);
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0; look();
    chk("t6_rdata", cpu_rdata, 32'hCAFE_0123);
    chk("t6_stall_rdv", cpu_stall, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick();

    // Randomized core workload; the core holds its request while stalled.
    for (int n = 0; n < 600; n++) begin
      ack_pct = (n < 200) ? 30 : ((n < 400) ? 80 : 10);
      op = $urandom_range(0, 19);
      ra = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      rd = $urandom;
      drive(op < 8 || op == 16, (op >= 8 && op < 17), ra, rd,
            $urandom_range(0, 99) < ack_pct);
      look();
      g = 0;
      while (cpu_stall && g < 200) begin
        @(posedge clk);
        #1;
        mem_ack = ($urandom_range(0, 99) < ack_pct);
        #1;
        g++;
      end
      if (g >= 200) chk("stall_bound", g, 0);
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
